// File: rtl/comparator_sweep_checker.sv
// -----------------------------------------------------------------------------
// comparator_sweep_checker
//
// Purpose
//   Stimulus and checking engine for a WIDTH-bit magnitude comparator with
//   g/e/l outputs. It walks every (a,b) operand pair through the comparator
//   under test and samples each g/e/l response. Each response is compared
//   against an internal golden compare. The engine counts mismatching pairs
//   and records the first pair that failed.
//
// Parameters
//   WIDTH    operand width in bits; one sweep covers 2^(2*WIDTH) pairs
//   LATENCY  response latency of the comparator in clk cycles (0 = comb.)
//
// Ports
//   clk          in   1          rising-edge clock
//   rst          in   1          asynchronous, active-high reset
//   start        in   1          begin a sweep (only looked at in IDLE)
//   a            out  WIDTH      operand A to the comparator
//   b            out  WIDTH      operand B to the comparator
//   g            in   1          comparator response: a > b
//   e            in   1          comparator response: a == b
//   l            in   1          comparator response: a < b
//   busy         out  1          high for every cycle of the DRIVE phase
//   done         out  1          one-cycle pulse when a sweep completes
//   pass         out  1          last sweep saw zero errors; held until start
//   err_count    out  2*WIDTH+1  mismatching pairs in the current/last sweep
//   first_valid  out  1          first_a/first_b hold a captured failure
//   first_a      out  WIDTH      operand A of the first failing pair
//   first_b      out  WIDTH      operand B of the first failing pair
// -----------------------------------------------------------------------------
module comparator_sweep_checker #(
  parameter int WIDTH   = 2,
  parameter int LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic               g,
  input  logic               e,
  input  logic               l,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_valid,
  output logic [WIDTH-1:0]   first_a,
  output logic [WIDTH-1:0]   first_b
);

  // ---------------------------------------------------------------------------
  // Derived sizes and constants
  // ---------------------------------------------------------------------------
  localparam int IDX_W  = 2 * WIDTH;
  localparam int CNT_W  = 2 * WIDTH + 1;
  // The hold counter needs to reach LATENCY; a one-bit counter that is never
  // incremented covers the combinational case.
  localparam int HOLD_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [IDX_W-1:0]  LAST_INDEX = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LATENCY);
  // Saturation ceiling equals the number of pairs in a sweep. This is only
  // reachable if every pair fails.
  localparam logic [CNT_W-1:0]  ERR_MAX    = {1'b1, {IDX_W{1'b0}}};

  // FSM encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state;
  logic [IDX_W-1:0]  index;
  logic [HOLD_W-1:0] hold;

  // ---------------------------------------------------------------------------
  // Operand drive
  // ---------------------------------------------------------------------------
  // The pair index is the operand bus itself: a is the upper half, b the lower.
  // The index is not advanced past the final pair. This keeps a/b parked on
  // the all-ones pair after a sweep until rst or the next start.
  assign a = index[IDX_W-1 -: WIDTH];
  assign b = index[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Golden compare and mismatch detection
  // ---------------------------------------------------------------------------
  logic [2:0] expected;
  logic [2:0] observed;
  logic       sample;
  logic       mismatch;
  logic       last_pair;

  assign expected  = {(a > b), (a == b), (a < b)};
  assign observed  = {g, e, l};
  // The response for the current pair is valid on the last cycle it is held.
  assign sample    = (state == DRIVE) && (hold == HOLD_LAST);
  // A full 3-bit compare catches wrong, missing and multiply-asserted flags.
  assign mismatch  = sample && (observed != expected);
  assign last_pair = (index == LAST_INDEX);

  logic [CNT_W-1:0] err_next;

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the edge, and their order in this block does
  // not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      index       <= '0;
      hold        <= '0;
      err_count   <= '0;
      pass        <= 1'b0;
      first_valid <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= DRIVE;
            index       <= '0;
            hold        <= '0;
            err_count   <= '0;
            pass        <= 1'b0;
            first_valid <= 1'b0;
          end
        end

        DRIVE: begin
          if (sample) begin
            err_count <= err_next;
            if (mismatch && !first_valid) begin
              first_valid <= 1'b1;
              first_a     <= a;
              first_b     <= b;
            end
            hold <= '0;
            if (last_pair) begin
              // Resolve pass on the final sample edge, including that pair's
              // verdict. The flag is then already valid while done is high.
              state <= FINISH;
              pass  <= (err_next == '0);
            end else begin
              index <= index + 1'b1;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status decode
  // ---------------------------------------------------------------------------
  // These are decoded straight from the state register. Because of that they
  // drop on the same instant an asynchronous reset lands.
  assign busy = (state == DRIVE);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_comparator_sweep_checker.sv
module tb_comparator_sweep_checker;

  localparam int WIDTH = 2;
  localparam int PAIRS = 16;

  logic clk = 1'b0;
  logic rst;
  logic start0, start2;

  // Instance with a combinational comparator model (LATENCY = 0)
  logic [WIDTH-1:0] a0, b0, fa0, fb0;
  logic             g0, e0, l0, busy0, done0, pass0, fv0;
  logic [4:0]       err0;

  // Instance with a 2-deep registered golden comparator (LATENCY = 2)
  logic [WIDTH-1:0] a2, b2, fa2, fb2;
  logic             g2, e2, l2, busy2, done2, pass2, fv2;
  logic [4:0]       err2;
  logic [2:0]       pipe1, pipe2;

  // 0 golden, 1 g/l swapped, 2 e stuck 1, 3 e stuck 0, 4 all flags stuck 0
  int fault_mode = 0;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected {a,b} values, one entry per DRIVE cycle
  logic [3:0] exp_q[$];

  // View of whichever instance the current scenario exercises
  logic             sel2 = 1'b0;
  logic [WIDTH-1:0] va, vb, vfa, vfb;
  logic             vbusy, vdone, vpass, vfv;
  logic [4:0]       verr;

  always #5 clk = ~clk;

  function automatic logic [2:0] golden(input logic [1:0] x, input logic [1:0] y);
    return {x > y, x == y, x < y};
  endfunction

  function automatic logic [2:0] faulty(input logic [1:0] x, input logic [1:0] y, input int mode);
    logic [2:0] r;
    r = golden(x, y);
    case (mode)
      1:       r = {r[0], r[1], r[2]};
      2:       r[1] = 1'b1;
      3:       r[1] = 1'b0;
      4:       r = 3'b000;
      default: ;
    endcase
    return r;
  endfunction

  always_comb {g0, e0, l0} = faulty(a0, b0, fault_mode);

  always @(posedge clk) begin
    pipe1 <= golden(a2, b2);
    pipe2 <= pipe1;
  end
  assign {g2, e2, l2} = pipe2;

  assign va    = sel2 ? a2    : a0;
  assign vb    = sel2 ? b2    : b0;
  assign vbusy = sel2 ? busy2 : busy0;
  assign vdone = sel2 ? done2 : done0;
  assign vpass = sel2 ? pass2 : pass0;
  assign vfv   = sel2 ? fv2   : fv0;
  assign vfa   = sel2 ? fa2   : fa0;
  assign vfb   = sel2 ? fb2   : fb0;
  assign verr  = sel2 ? err2  : err0;

  comparator_sweep_checker #(.WIDTH(WIDTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
    .g(g0), .e(e0), .l(l0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_valid(fv0), .first_a(fa0), .first_b(fb0)
  );

  comparator_sweep_checker #(.WIDTH(WIDTH), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .g(g2), .e(e2), .l(l2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_valid(fv2), .first_a(fa2), .first_b(fb2)
  );

  // Run one full sweep and check it. Expected error figures come from the
  // fault table: swapped g/l and stuck-1 e fail on the 12 unequal pairs, and
  // stuck-0 e fails on the 4 equal pairs. All-zero flags fail on all 16.
  task automatic run_sweep(input string tag, input bit use2, input int lat, input int mode,
                           input bit pulse_again, input int exp_err, input bit exp_fv,
                           input logic [1:0] exp_fa, input logic [1:0] exp_fb);
    int cycles;
    int budget;
    logic [3:0] want;
    sel2 = use2;
    fault_mode = mode;
    exp_q.delete();
    for (int p = 0; p < PAIRS; p++)
      for (int h = 0; h <= lat; h++) exp_q.push_back(4'(p));

    @(negedge clk);
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;

    cycles = 0;
    budget = PAIRS * (lat + 1) + 8;
    while (vbusy === 1'b1 && cycles < budget) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s extra_busy_cycle: busy still 1 at cycle %0d, required 0", tag, cycles);
      end else begin
        want = exp_q.pop_front();
        if ({va, vb} !== want) begin
          failures++;
          $display("FAIL %s pair_cycle%0d: a/b=%h required %h", tag, cycles, {va, vb}, want);
        end
      end
      checks++;
      if (vdone !== 1'b0) begin
        failures++;
        $display("FAIL %s done_in_drive: done=%b at cycle %0d, required 0", tag, vdone, cycles);
      end
      if (pulse_again) begin
        if (use2) start2 = (cycles == 3); else start0 = (cycles == 3);
      end
      cycles++;
      @(negedge clk);
    end
    start0 = 1'b0;
    start2 = 1'b0;

    checks++;
    if (cycles != PAIRS * (lat + 1)) begin
      failures++;
      $display("FAIL %s busy_length: %0d cycles, required %0d", tag, cycles, PAIRS * (lat + 1));
    end
    checks++;
    if (vdone !== 1'b1) begin
      failures++;
      $display("FAIL %s done_pulse: done=%b, required 1", tag, vdone);
    end
    checks++;
    if (vpass !== (exp_err == 0)) begin
      failures++;
      $display("FAIL %s pass: got %b required %b", tag, vpass, exp_err == 0);
    end
    checks++;
    if (verr !== 5'(exp_err)) begin
      failures++;
      $display("FAIL %s err_count: got %0d required %0d", tag, verr, exp_err);
    end
    checks++;
    if (vfv !== exp_fv) begin
      failures++;
      $display("FAIL %s first_valid: got %b required %b", tag, vfv, exp_fv);
    end
    if (exp_fv) begin
      checks++;
      if ({vfa, vfb} !== {exp_fa, exp_fb}) begin
        failures++;
        $display("FAIL %s first_pair: got %0d/%0d required %0d/%0d", tag, vfa, vfb, exp_fa, exp_fb);
      end
    end

    @(negedge clk);
    checks++;
    if (vdone !== 1'b0 || vbusy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b, required 0 0", tag, vdone, vbusy);
    end
    checks++;
    if ({va, vb} !== 4'hF || verr !== 5'(exp_err) || vpass !== (exp_err == 0)) begin
      failures++;
      $display("FAIL %s idle_hold: a/b=%h err=%0d pass=%b, required f %0d %b",
               tag, {va, vb}, verr, vpass, exp_err, exp_err == 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    #1;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, fa0, fb0} !== '0) begin
      failures++;
      $display("FAIL reset_dut0: outputs not all 0 (a/b=%h busy=%b err=%0d)", {a0, b0}, busy0, err0);
    end
    checks++;
    if ({a2, b2, busy2, done2, pass2, err2, fv2, fa2, fb2} !== '0) begin
      failures++;
      $display("FAIL reset_dut2: outputs not all 0 (a/b=%h busy=%b err=%0d)", {a2, b2}, busy2, err2);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    sel2 = 1'b0;
    fault_mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({a0, b0} !== 4'd5 || err0 !== 5'd4 || fv0 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_pre: a/b=%h err=%0d fv=%b, required 5 4 1", {a0, b0}, err0, fv0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, fa0, fb0} !== '0) begin
      failures++;
      $display("FAIL mid_reset_async: a/b=%h busy=%b err=%0d fv=%b, required all 0",
               {a0, b0}, busy0, err0, fv0);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL mid_reset_no_done: done/busy seen after abort, required none");
    end
    run_sweep("after_reset", 1'b0, 0, 0, 1'b0, 0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_hold_start();
    int guard;
    sel2 = 1'b0;
    fault_mode = 0;
    @(negedge clk);
    start0 = 1'b1;
    guard = 0;
    while (done0 !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (done0 !== 1'b1) begin
      failures++;
      $display("FAIL hold_start_done: no done within 40 cycles");
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || {a0, b0} !== 4'hF) begin
      failures++;
      $display("FAIL hold_start_idle: busy=%b a/b=%h, required 0 f", busy0, {a0, b0});
    end
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || {a0, b0} !== 4'h0) begin
      failures++;
      $display("FAIL hold_start_restart: busy=%b a/b=%h, required 1 0", busy0, {a0, b0});
    end
    guard = 0;
    while (done0 !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1) begin
      failures++;
      $display("FAIL hold_start_second: done=%b pass=%b, required 1 1", done0, pass0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    run_sweep("golden",    1'b0, 0, 0, 1'b0, 0,  1'b0, 2'd0, 2'd0);
    run_sweep("swap_gl",   1'b0, 0, 1, 1'b0, 12, 1'b1, 2'd0, 2'd1);
    run_sweep("e_stuck1",  1'b0, 0, 2, 1'b0, 12, 1'b1, 2'd0, 2'd1);
    run_sweep("e_stuck0",  1'b0, 0, 3, 1'b0, 4,  1'b1, 2'd0, 2'd0);
    run_sweep("all_zero",  1'b0, 0, 4, 1'b0, 16, 1'b1, 2'd0, 2'd0);
    run_sweep("latency2",  1'b1, 2, 0, 1'b0, 0,  1'b0, 2'd0, 2'd0);
    test_reset_mid();
    run_sweep("back_to_back", 1'b0, 0, 0, 1'b1, 0, 1'b0, 2'd0, 2'd0);
    test_hold_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
